bpress_arbiter: RTL

//   Shares one downstream command consumer among N_BTN shaped pushbuttons.

---
 rtl/bpress_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bpress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bpress_arbiter
// Description : Latches shaped button presses, grants them round-robin and
//               queues the granted button IDs behind a valid/ready port.
// Revision    : 1.0  initial release
// ============================================================================
module bpress_arbiter #(
   parameter int N_BTN      = 4,
   parameter int ID_W       = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_BTN-1:0] btn_pulse,
   input  logic             evt_ready,
   output logic             evt_valid,
   output logic [ID_W-1:0]  evt_id,
   output logic [N_BTN-1:0] pending,
   output logic             overflow
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
   localparam logic [ID_W:0]      c_NBTN = (ID_W+1)'(N_BTN);
   localparam logic [ID_W-1:0]    c_LAST = ID_W'(N_BTN - 1);

   logic [N_BTN-1:0]   r_pend;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [ID_W-1:0]    r_mem [FIFO_DEPTH];
   logic               r_overflow;

   logic [2*N_BTN-1:0] w_dbl;
   logic [N_BTN-1:0]   w_rot;
   logic               w_can_push;
   logic               w_found;
   logic               w_grant;
   logic [ID_W-1:0]    w_ofs;
   logic [ID_W:0]      w_sum;
   logic [ID_W-1:0]    w_gnt_id;
   logic [ID_W-1:0]    w_rr_next;
   logic [N_BTN-1:0]   w_gnt_vec;
   logic [N_BTN-1:0]   w_pend_next;
   logic               w_drop;
   logic               w_pop;

   assign w_can_push = (r_count < c_FULL);
   assign w_pop      = evt_valid && evt_ready;

   // Rotate pending so the search always starts at bit 0 of w_rot.
   assign w_dbl = {r_pend, r_pend} >> r_rr_ptr;
   assign w_rot = w_dbl[N_BTN-1:0];

   always_comb begin
      w_found = 1'b0;
      w_ofs   = '0;
      for (int k = 0; k < N_BTN; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_ofs   = ID_W'(k);
         end
      end
   end

   assign w_grant  = w_found && w_can_push;
   assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_ofs};

   always_comb begin
      w_gnt_id = '0;
      if (w_sum >= c_NBTN) begin
         w_gnt_id = ID_W'(w_sum - c_NBTN);
      end else begin
         w_gnt_id = w_sum[ID_W-1:0];
      end
   end

   assign w_rr_next = (w_gnt_id == c_LAST) ? '0 : w_gnt_id + 1'b1;

   // A new pulse on a bit takes priority over the grant clearing it.
   always_comb begin
      w_gnt_vec   = '0;
      w_pend_next = r_pend;
      w_drop      = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
         w_gnt_vec[i] = w_grant && (w_gnt_id == ID_W'(i));
         if (btn_pulse[i] && r_pend[i] && !w_gnt_vec[i]) begin
            w_drop = 1'b1;
         end else if (btn_pulse[i]) begin
            w_pend_next[i] = 1'b1;
         end else if (w_gnt_vec[i]) begin
            w_pend_next[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pend     <= '0;
         r_rr_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         for (int j = 0; j < FIFO_DEPTH; j++) begin
            r_mem[j] <= '0;
         end
      end else begin
         r_pend <= w_pend_next;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_grant) begin
            r_mem[r_wr_ptr] <= w_gnt_id;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            r_rr_ptr        <= w_rr_next;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_grant, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign evt_valid = (r_count != '0);
   assign evt_id    = r_mem[r_rd_ptr];
   assign pending   = r_pend;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire
